// File: rtl/rew_path_stream_tagger.sv
// Path stream tagger: forwards ORAM path bursts from DRAM tagged with
// bucket index, header flag and path-last flag; RO mode drops payloads.
// Ports: Clock/Reset; PathStart, ROAccess, PathBusy (path control);
// DRAMReadData/Valid/Ready (input stream); DataOut/Valid/Ready (output
// stream); BucketIdx, IsHeader, PathLast (tags of DataOut).
// Optional macro REW_PATH_PARITY_EN adds PathParity (XOR of path beats).
module rew_path_stream_tagger #(
    parameter int ORAML         = 31,
    parameter int DataWidth     = 512,
    parameter int HeaderBursts  = 1,
    parameter int PayloadBursts = 5,
    localparam int BIdxWidth    = (ORAML + 1 > 1) ? $clog2(ORAML + 1) : 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 PathStart,
    input  logic                 ROAccess,
    output logic                 PathBusy,
    input  logic [DataWidth-1:0] DRAMReadData,
    input  logic                 DRAMReadDataValid,
    output logic                 DRAMReadDataReady,
    output logic [DataWidth-1:0] DataOut,
    output logic                 DataOutValid,
    input  logic                 DataOutReady,
    output logic [BIdxWidth-1:0] BucketIdx,
    output logic                 IsHeader,
    output logic                 PathLast
`ifdef REW_PATH_PARITY_EN
    ,
    output logic [DataWidth-1:0] PathParity
`endif
);

    localparam int MaxBursts = (HeaderBursts > PayloadBursts) ? HeaderBursts : PayloadBursts;
    localparam int CntWidth  = (MaxBursts > 1) ? $clog2(MaxBursts) : 1;

    localparam logic [CntWidth-1:0]  HdrLast = CntWidth'(HeaderBursts - 1);
    localparam logic [CntWidth-1:0]  PayLast = CntWidth'(PayloadBursts - 1);
    localparam logic [BIdxWidth-1:0] RootIdx = BIdxWidth'(ORAML);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_e;

    state_e                 state_q, state_d;
    logic                   ro_q, ro_d;
    logic [BIdxWidth-1:0]   bucket_q, bucket_d;
    logic [CntWidth-1:0]    burst_q, burst_d;
    logic [DataWidth-1:0]   dout_q, dout_d;
    logic                   vld_q, vld_d;
    logic [BIdxWidth-1:0]   bidx_q, bidx_d;
    logic                   hdr_q, hdr_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;

    logic discard;
    logic in_ready;
    logic in_fire;
    logic fwd;
    logic start;
    logic out_fire;
    logic hdr_end;
    logic pay_end;
    logic at_root;

    // RO payload bursts bypass the output register, so they never
    // wait on downstream back-pressure.
    assign discard  = (state_q == PAYLOAD) & ro_q;
    assign in_ready = (state_q != IDLE) & (discard | ~vld_q | DataOutReady);
    assign in_fire  = DRAMReadDataValid & in_ready;
    assign fwd      = in_fire & ~discard;
    assign start    = (state_q == IDLE) & PathStart;
    assign out_fire = vld_q & DataOutReady;
    assign hdr_end  = (burst_q == HdrLast);
    assign pay_end  = (burst_q == PayLast);
    assign at_root  = (bucket_q == RootIdx);

    always_comb begin
        state_d  = state_q;
        ro_d     = ro_q;
        bucket_d = bucket_q;
        burst_d  = burst_q;
        dout_d   = dout_q;
        vld_d    = vld_q;
        bidx_d   = bidx_q;
        hdr_d    = hdr_q;
        last_d   = last_q;
        busy_d   = busy_q;

        if (out_fire) begin
            vld_d = 1'b0;
        end
        if (out_fire & last_q) begin
            busy_d = 1'b0;
        end
        if (fwd) begin
            vld_d  = 1'b1;
            dout_d = DRAMReadData;
            bidx_d = bucket_q;
            hdr_d  = (state_q == HEADER);
            last_d = at_root & (ro_q ? ((state_q == HEADER) & hdr_end)
                                     : ((state_q == PAYLOAD) & pay_end));
        end

        unique case (state_q)
            IDLE: begin
                // A new start wins over the old path's final busy clear.
                if (start) begin
                    state_d  = HEADER;
                    ro_d     = ROAccess;
                    bucket_d = '0;
                    burst_d  = '0;
                    busy_d   = 1'b1;
                end
            end
            HEADER: begin
                if (in_fire) begin
                    if (hdr_end) begin
                        state_d = PAYLOAD;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (in_fire) begin
                    if (pay_end) begin
                        burst_d = '0;
                        if (at_root) begin
                            state_d = IDLE;
                        end else begin
                            bucket_d = bucket_q + 1'b1;
                            state_d  = HEADER;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ro_q     <= 1'b0;
            bucket_q <= '0;
            burst_q  <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            bidx_q   <= '0;
            hdr_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ro_q     <= ro_d;
            bucket_q <= bucket_d;
            burst_q  <= burst_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            bidx_q   <= bidx_d;
            hdr_q    <= hdr_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

    assign DRAMReadDataReady = in_ready;
    assign DataOut           = dout_q;
    assign DataOutValid      = vld_q;
    assign BucketIdx         = bidx_q;
    assign IsHeader          = hdr_q;
    assign PathLast          = last_q;
    assign PathBusy          = busy_q;

`ifdef REW_PATH_PARITY_EN
    logic [DataWidth-1:0] parity_q, parity_d;

    // Accumulated as beats enter the output register, so the value
    // already includes the beat currently presented on DataOut.
    always_comb begin
        parity_d = parity_q;
        if (start) begin
            parity_d = '0;
        end else if (fwd) begin
            parity_d = parity_q ^ DRAMReadData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign PathParity = parity_q;
`endif

endmodule

// File: tb/tb_rew_path_stream_tagger.sv
// Directed self-checking bench for rew_path_stream_tagger
// (ORAML=3, HeaderBursts=1, PayloadBursts=5, 32-bit data).
module tb_rew_path_stream_tagger;

    localparam int DW     = 32;
    localparam int BUDGET = 400;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          PathStart = 1'b0;
    logic          ROAccess = 1'b0;
    logic          PathBusy;
    logic [DW-1:0] DRAMReadData = '0;
    logic          DRAMReadDataValid = 1'b0;
    logic          DRAMReadDataReady;
    logic [DW-1:0] DataOut;
    logic          DataOutValid;
    logic          DataOutReady = 1'b0;
    logic [1:0]    BucketIdx;
    logic          IsHeader;
    logic          PathLast;
`ifdef REW_PATH_PARITY_EN
    logic [DW-1:0] PathParity;
`endif

    rew_path_stream_tagger #(
        .ORAML(3),
        .DataWidth(DW),
        .HeaderBursts(1),
        .PayloadBursts(5)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .PathStart(PathStart),
        .ROAccess(ROAccess),
        .PathBusy(PathBusy),
        .DRAMReadData(DRAMReadData),
        .DRAMReadDataValid(DRAMReadDataValid),
        .DRAMReadDataReady(DRAMReadDataReady),
        .DataOut(DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady),
        .BucketIdx(BucketIdx),
        .IsHeader(IsHeader),
        .PathLast(PathLast)
`ifdef REW_PATH_PARITY_EN
        ,
        .PathParity(PathParity)
`endif
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] b_data[$];
    logic [1:0]    b_bidx[$];
    logic          b_hdr[$];
    logic          b_last[$];
    int            tot_acc;
    int            stall_chk;
    int            stall_bad;
    bit            timed_out;
    logic [DW-1:0] par_last;
    bit            par_seen;

    // Drives one or more paths and records every downstream beat.
    task automatic run(input bit ro, input bit toggle, input int poke_at,
                       input int paths, input int stop_beats);
        int in_cnt;
        int done;
        int cyc;
        bit acc;
        bit hold;
        logic [DW-1:0] h_data;
        logic [1:0] h_bidx;
        logic h_hdr;
        logic h_last;
        b_data.delete();
        b_bidx.delete();
        b_hdr.delete();
        b_last.delete();
        tot_acc = 0;
        stall_chk = 0;
        stall_bad = 0;
        timed_out = 1'b1;
        par_seen = 1'b0;
        par_last = '0;
        in_cnt = 0;
        done = 0;
        hold = 1'b0;
        h_data = '0;
        h_bidx = '0;
        h_hdr = 1'b0;
        h_last = 1'b0;
        DRAMReadData = '0;
        DRAMReadDataValid = 1'b1;
        ROAccess = ro;
        PathStart = 1'b1;
        for (cyc = 0; cyc < BUDGET; cyc++) begin
            DataOutReady = toggle ? (cyc % 2 == 0) : 1'b1;
            if (cyc == poke_at) begin
                PathStart = 1'b1;
                ROAccess = 1'b1;
            end
            @(negedge Clock);
            if (hold) begin
                stall_chk++;
                if (!DataOutValid || DataOut !== h_data || BucketIdx !== h_bidx ||
                    IsHeader !== h_hdr || PathLast !== h_last)
                    stall_bad++;
            end
            hold = DataOutValid && !DataOutReady;
            h_data = DataOut;
            h_bidx = BucketIdx;
            h_hdr = IsHeader;
            h_last = PathLast;
            if (DataOutValid && DataOutReady) begin
                b_data.push_back(DataOut);
                b_bidx.push_back(BucketIdx);
                b_hdr.push_back(IsHeader);
                b_last.push_back(PathLast);
`ifdef REW_PATH_PARITY_EN
                if (PathLast) begin
                    par_last = PathParity;
                    par_seen = 1'b1;
                end
`endif
            end
            acc = DRAMReadDataValid && DRAMReadDataReady;
            @(posedge Clock);
            #1;
            PathStart = 1'b0;
            ROAccess = ro;
            if (acc) begin
                tot_acc++;
                in_cnt++;
                if (in_cnt == 24) begin
                    done++;
                    in_cnt = 0;
                    if (done < paths) PathStart = 1'b1;
                end
                DRAMReadData = DW'(in_cnt);
            end
            if (stop_beats >= 0 && b_data.size() >= stop_beats) begin
                timed_out = 1'b0;
                break;
            end
            if (done == paths && !PathBusy && !DataOutValid) begin
                timed_out = 1'b0;
                break;
            end
        end
        DataOutReady = 1'b1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        vectors++;
        if ({DataOutValid, DRAMReadDataReady, PathBusy, IsHeader, PathLast} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {DataOutValid, DRAMReadDataReady, PathBusy, IsHeader, PathLast});
        end
        vectors++;
        if (DataOut !== '0 || BucketIdx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%0d want 0/0", DataOut, BucketIdx);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        vectors++;
        if (DRAMReadDataReady !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: got %b want 0", DRAMReadDataReady);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_rw_path;
        run(1'b0, 1'b0, -1, 1, -1);
        vectors++;
        if (timed_out || b_data.size() != 24 || tot_acc != 24) begin
            miscompares++;
            $display("FAIL rw_count: got beats %0d acc %0d to %0b want 24 24 0",
                     b_data.size(), tot_acc, timed_out);
        end
        for (int i = 0; i < b_data.size() && i < 24; i++) begin
            vectors++;
            if (b_data[i] !== DW'(i) || b_bidx[i] !== 2'(i / 6) ||
                b_hdr[i] !== (i % 6 == 0) || b_last[i] !== (i == 23)) begin
                miscompares++;
                $display("FAIL rw_beat%0d: got d%0d b%0d h%b l%b want d%0d b%0d h%b l%b",
                         i, b_data[i], b_bidx[i], b_hdr[i], b_last[i],
                         i, i / 6, (i % 6 == 0), (i == 23));
            end
        end
        vectors++;
        if (PathBusy !== 1'b0 || DRAMReadDataReady !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_end: got busy %b ready %b want 0 0",
                     PathBusy, DRAMReadDataReady);
        end
    endtask

    task automatic test_ro_path;
        run(1'b1, 1'b0, -1, 1, -1);
        vectors++;
        if (timed_out || b_data.size() != 4 || tot_acc != 24) begin
            miscompares++;
            $display("FAIL ro_count: got beats %0d acc %0d to %0b want 4 24 0",
                     b_data.size(), tot_acc, timed_out);
        end
        for (int i = 0; i < b_data.size() && i < 4; i++) begin
            vectors++;
            if (b_data[i] !== DW'(6 * i) || b_bidx[i] !== 2'(i) ||
                b_hdr[i] !== 1'b1 || b_last[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL ro_beat%0d: got d%0d b%0d h%b l%b want d%0d b%0d h1 l%b",
                         i, b_data[i], b_bidx[i], b_hdr[i], b_last[i],
                         6 * i, i, (i == 3));
            end
        end
    endtask

    task automatic test_stall;
        run(1'b0, 1'b1, -1, 1, -1);
        vectors++;
        if (timed_out || b_data.size() != 24) begin
            miscompares++;
            $display("FAIL stall_count: got %0d to %0b want 24 0", b_data.size(), timed_out);
        end
        vectors++;
        if (stall_chk == 0 || stall_bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold: got %0d unstable of %0d stalls want 0 of >0",
                     stall_bad, stall_chk);
        end
        for (int i = 0; i < b_data.size() && i < 24; i++) begin
            vectors++;
            if (b_data[i] !== DW'(i) || b_bidx[i] !== 2'(i / 6) ||
                b_hdr[i] !== (i % 6 == 0) || b_last[i] !== (i == 23)) begin
                miscompares++;
                $display("FAIL stall_beat%0d: got d%0d b%0d h%b l%b", i,
                         b_data[i], b_bidx[i], b_hdr[i], b_last[i]);
            end
        end
    endtask

    task automatic test_restart_ignored;
        run(1'b0, 1'b0, 8, 1, -1);
        vectors++;
        if (timed_out || b_data.size() != 24 || tot_acc != 24) begin
            miscompares++;
            $display("FAIL poke_count: got beats %0d acc %0d want 24 24",
                     b_data.size(), tot_acc);
        end
        for (int i = 0; i < b_data.size() && i < 24; i++) begin
            vectors++;
            if (b_data[i] !== DW'(i) || b_bidx[i] !== 2'(i / 6) ||
                b_hdr[i] !== (i % 6 == 0) || b_last[i] !== (i == 23)) begin
                miscompares++;
                $display("FAIL poke_beat%0d: got d%0d b%0d h%b l%b", i,
                         b_data[i], b_bidx[i], b_hdr[i], b_last[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        run(1'b0, 1'b0, -1, 1, 10);
        vectors++;
        if (timed_out || b_data.size() != 10 || PathBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got beats %0d busy %b want 10 1",
                     b_data.size(), PathBusy);
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if ({DataOutValid, DRAMReadDataReady, PathBusy, IsHeader, PathLast} !== 5'b0 ||
            DataOut !== '0 || BucketIdx !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got v%b r%b b%b h%b l%b d%0d i%0d want all 0",
                     DataOutValid, DRAMReadDataReady, PathBusy, IsHeader,
                     PathLast, DataOut, BucketIdx);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        run(1'b0, 1'b0, -1, 1, -1);
        vectors++;
        if (b_data.size() != 24) begin
            miscompares++;
            $display("FAIL post_reset_count: got %0d want 24", b_data.size());
        end else if (b_data[0] !== '0 || b_bidx[0] !== 2'd0 || b_hdr[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_first: got d%0d b%0d h%b want 0 0 1",
                     b_data[0], b_bidx[0], b_hdr[0]);
        end
    endtask

    task automatic test_back_to_back;
        run(1'b0, 1'b0, -1, 2, -1);
        vectors++;
        if (timed_out || b_data.size() != 48 || tot_acc != 48) begin
            miscompares++;
            $display("FAIL b2b_count: got beats %0d acc %0d want 48 48",
                     b_data.size(), tot_acc);
        end
        for (int i = 0; i < b_data.size() && i < 48; i++) begin
            vectors++;
            if (b_data[i] !== DW'(i % 24) || b_bidx[i] !== 2'((i % 24) / 6) ||
                b_hdr[i] !== (i % 6 == 0) || b_last[i] !== (i % 24 == 23)) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: got d%0d b%0d h%b l%b", i,
                         b_data[i], b_bidx[i], b_hdr[i], b_last[i]);
            end
        end
    endtask

`ifdef REW_PATH_PARITY_EN
    task automatic test_parity;
        run(1'b0, 1'b0, -1, 1, -1);
        vectors++;
        if (!par_seen || par_last !== '0) begin
            miscompares++;
            $display("FAIL parity: got seen %b val %h want 1 0", par_seen, par_last);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rw_path();
        test_ro_path();
        test_stall();
        test_restart_ignored();
        test_back_to_back();
        test_mid_reset();
`ifdef REW_PATH_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rew_path_stream_tagger.md
REW_PATH_STREAM_TAGGER -- requirements
Module: rew_path_stream_tagger

Interface
REQ-001 SHALL have parameter ORAML, 31, path has ORAML+1 buckets, leaf to root.
REQ-002 SHALL have parameter DataWidth, 512, DRAM burst width in bits.
REQ-003 SHALL have parameter HeaderBursts, 1, header bursts per bucket; legal range 1 or more.
REQ-004 SHALL have parameter PayloadBursts, 5, payload bursts per bucket; legal range 1 or more.
REQ-005 SHALL have localparam BIdxWidth = clog2(ORAML+1), with a minimum of 1.
REQ-006 SHALL have port Clock, input, 1, sole clock; all state is updated on its rising edge.
REQ-007 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port PathStart, input, 1, one-cycle request to begin a path.
REQ-009 SHALL have port ROAccess, input, 1, mode sampled with PathStart: 1 = RO, 0 = RW.
REQ-010 SHALL have port PathBusy, output, 1, high from an accepted PathStart until the last burst of the path is emitted.
REQ-011 SHALL have port DRAMReadData, input, DataWidth, incoming burst.
REQ-012 SHALL have port DRAMReadDataValid, input, 1, valid for the incoming burst.
REQ-013 SHALL have port DRAMReadDataReady, output, 1, ready for the incoming burst.
REQ-014 SHALL have port DataOut, output, DataWidth, forwarded burst.
REQ-015 SHALL have port DataOutValid, output, 1, valid for the forwarded burst.
REQ-016 SHALL have port DataOutReady, input, 1, ready for the forwarded burst.
REQ-017 SHALL have port BucketIdx, output, BIdxWidth, bucket index of DataOut; 0 = leaf.
REQ-018 SHALL have port IsHeader, output, 1, high when DataOut is a header burst.
REQ-019 SHALL have port PathLast, output, 1, high when DataOut is the final forwarded burst of the path.

Function
REQ-020 SHALL implement states IDLE, HEADER and PAYLOAD.
REQ-021 SHALL, in IDLE, hold DRAMReadDataReady low; PathStart moves the block to HEADER, latches ROAccess, and clears the bucket and burst counters.
REQ-022 SHALL ignore PathStart outside IDLE, with no change to the latched mode or counters.
REQ-023 SHALL count an input burst only on DRAMReadDataValid & DRAMReadDataReady.
REQ-024 SHALL move from HEADER to PAYLOAD after HeaderBursts accepted bursts.
REQ-025 SHALL, after PayloadBursts accepted payload bursts, increment the bucket index and return to HEADER; after bucket ORAML it returns to IDLE.
REQ-026 SHALL, in RW mode, forward every burst with tags.
REQ-027 SHALL, in RO mode, accept payload bursts and discard them, and forward header bursts only.
REQ-028 SHALL register the output stage with 1-cycle latency from an accepted input to DataOutValid.
REQ-029 SHALL drive DRAMReadDataReady = (state != IDLE) & (~DataOutValid | DataOutReady), or 1 for a discarded RO payload burst while in PAYLOAD.
REQ-030 SHALL hold DataOut and the tags stable while DataOutValid & ~DataOutReady.
REQ-031 SHALL sustain one burst per cycle under DataOutReady = 1.
REQ-032 SHALL assert PathLast on the last payload burst of bucket ORAML in RW mode, or on the last header burst of bucket ORAML in RO mode.
REQ-033 SHALL drop PathBusy in the cycle after the PathLast beat is accepted downstream.
REQ-034 SHALL allow a PathStart to be accepted in the same cycle the block re-enters IDLE.

Reset
REQ-035 SHALL, on Reset, immediately set state IDLE, counters 0, DataOutValid 0, DRAMReadDataReady 0, PathBusy 0, BucketIdx 0, IsHeader 0, PathLast 0 and DataOut 0.
REQ-036 SHALL, on a mid-path Reset, discard the partial path and the output register contents with no further output.

Configuration
REQ-037 SHALL compile in, when REW_PATH_PARITY_EN is defined, an output PathParity [DataWidth-1:0] equal to the XOR of all forwarded DataOut beats of the path, valid with the PathLast beat and cleared at PathStart and at Reset.
REQ-038 SHALL, without REW_PATH_PARITY_EN, have no PathParity port and no parity logic.

Verification
REQ-039 SHALL verify: ORAML=3, HeaderBursts=1, PayloadBursts=5, RW, DRAM valid always, DataOutReady=1 -> 24 beats out, BucketIdx 0,0..3, IsHeader on beats 0,6,12,18, PathLast on beat 23 only.
REQ-040 SHALL verify: same configuration in RO mode -> 24 bursts accepted, 4 beats out (all IsHeader, BucketIdx 0..3), PathLast on the 4th.
REQ-041 SHALL verify: DataOutReady toggling 1,0 in RW mode -> DataOut held stable during stall, no beats lost or duplicated, 24 beats out in order.
REQ-042 SHALL verify: PathStart pulsed again mid-path with ROAccess=1 -> ignored; the path completes in the original RW mode.
REQ-043 SHALL verify: Reset asserted after 10 beats -> outputs 0 immediately; a new PathStart then restarts at BucketIdx 0 with IsHeader=1.
REQ-044 SHALL verify, with REW_PATH_PARITY_EN: DRAMReadData = beat index, RW mode -> PathParity = XOR(0..23) = 0 on PathLast.
